// File: rtl/step_display_pkg.sv
// Shared constants and the hex-to-seven-segment decode for step_display_ctrl.
package step_display_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for 0-9, A, b, C, d, E, F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/step_display_ctrl_btn_debounce.sv
// Two-flop synchronizer, stability-counting debouncer and rising-edge detect
// for one board push-button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic rise
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             btn_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_dly_q;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (btn_s_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = btn_s_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            btn_s_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
        end else begin
            sync1_q     <= btn_in;
            btn_s_q     <= sync1_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
        end
    end

    // High for the single cycle after the accepted level rises; release is ignored
    assign rise = level_q & ~level_dly_q;

endmodule

// File: rtl/step_display_ctrl.sv
// Step-button front end and 4-digit hex display mux for the MIPS pipeline board.
// Define STEP_DISPLAY_AUTO_RUN_EN to add the run_sw auto-stepping mode.
module step_display_ctrl
    import step_display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REFRESH_DIV     = 100000
`ifdef STEP_DISPLAY_AUTO_RUN_EN
    ,
    parameter int AUTO_PERIOD     = 50000000
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_btn,
    input  logic        show_pc,
    input  logic        half_sel,
    input  logic [31:0] pc_in,
    input  logic [31:0] probe_data,
`ifdef STEP_DISPLAY_AUTO_RUN_EN
    input  logic        run_sw,
`endif
    output logic        step_pulse,
    output logic [15:0] step_count,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int               REF_W    = $clog2(REFRESH_DIV + 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam int               IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic btn_rise;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_btn (
        .clk   (clk),
        .reset (reset),
        .btn_in(step_btn),
        .rise  (btn_rise)
    );

    logic             step_pulse_q, step_pulse_d;
    logic [15:0]      step_count_q, step_count_d;
    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      snap_q, snap_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             ref_wrap;
    logic [31:0]      src_word;

`ifdef STEP_DISPLAY_AUTO_RUN_EN
    localparam int               AUTO_W    = $clog2(AUTO_PERIOD + 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

    logic              run_s1_q, run_s_q;
    logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
    logic              auto_fire;

    // Button pulses are dropped while auto-run owns the step enable
    always_comb begin
        auto_fire    = run_s_q && (auto_cnt_q == AUTO_LAST);
        auto_cnt_d   = (!run_s_q || auto_fire) ? '0 : auto_cnt_q + 1'b1;
        step_pulse_d = run_s_q ? auto_fire : btn_rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_s1_q   <= 1'b0;
            run_s_q    <= 1'b0;
            auto_cnt_q <= '0;
        end else begin
            run_s1_q   <= run_sw;
            run_s_q    <= run_s1_q;
            auto_cnt_q <= auto_cnt_d;
        end
    end
`else
    always_comb begin
        step_pulse_d = btn_rise;
    end
`endif

    always_comb begin
        step_count_d = step_count_q + {15'd0, step_pulse_d};

        ref_wrap  = (ref_cnt_q == REF_LAST);
        ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;

        idx_d = idx_q;
        if (ref_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // The word is captured only as digit 3 hands back to digit 0, so a
        // full scan always shows one consistent value
        src_word = show_pc ? pc_in : probe_data;
        snap_d   = snap_q;
        if (ref_wrap && (idx_q == IDX_LAST)) begin
            snap_d = half_sel ? src_word[31:16] : src_word[15:0];
        end

        an_d  = ~(4'b0001 << idx_d);
        seg_d = hex_to_seg(snap_d[{idx_d, 2'b00} +: 4]);
        dp_d  = !((idx_d == IDX_LAST) && half_sel);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_pulse_q <= 1'b0;
            step_count_q <= '0;
            ref_cnt_q    <= '0;
            idx_q        <= '0;
            snap_q       <= '0;
            an_q         <= 4'b1110;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
        end else begin
            step_pulse_q <= step_pulse_d;
            step_count_q <= step_count_d;
            ref_cnt_q    <= ref_cnt_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign step_pulse = step_pulse_q;
    assign step_count = step_count_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;

endmodule

// File: tb/tb_step_display_ctrl.sv
// Self-checking bench for step_display_ctrl: timeline model plus directed vectors.
module tb_step_display_ctrl;

    localparam int D = 4;
    localparam int R = 3;
    localparam int P = 5;

    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        reset, step_btn, show_pc, half_sel;
    logic [31:0] pc_in, probe_data;
    logic        step_pulse, dp;
    logic [15:0] step_count;
    logic [3:0]  an;
    logic [6:0]  seg;
`ifdef STEP_DISPLAY_AUTO_RUN_EN
    logic        run_sw;
`endif

    always #5 clk = ~clk;

    step_display_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .REFRESH_DIV    (R)
`ifdef STEP_DISPLAY_AUTO_RUN_EN
        ,
        .AUTO_PERIOD    (P)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .step_btn  (step_btn),
        .show_pc   (show_pc),
        .half_sel  (half_sel),
        .pc_in     (pc_in),
        .probe_data(probe_data),
`ifdef STEP_DISPLAY_AUTO_RUN_EN
        .run_sw    (run_sw),
`endif
        .step_pulse(step_pulse),
        .step_count(step_count),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    int vectors = 0;
    int misses  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: everything derived from edge counts since reset
    bit          m_valid = 1'b0;
    bit          m_s1, m_s2, m_bs, m_level, m_rose_prev, m_rose_now, m_pulse, m_fire;
    int          m_run, m_k, m_d;
    logic [15:0] m_count, m_snap;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    bit          m_dp;
    bit          m_r1, m_r2, m_run_old;
    int          m_auto_n;

    always @(posedge clk) begin
        m_valid = 1'b1;
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_rose_prev = 0;
            m_r1 = 0; m_r2 = 0; m_auto_n = 0;
            m_pulse = 0; m_count = '0; m_k = 0; m_snap = '0;
            m_an = 4'b1110; m_seg = 7'h7F; m_dp = 1;
        end else begin
            m_bs = m_s2; m_s2 = m_s1; m_s1 = step_btn;
            m_run_old = m_r2;
`ifdef STEP_DISPLAY_AUTO_RUN_EN
            m_r2 = m_r1; m_r1 = run_sw;
`endif
            // A new level is accepted after D consecutive samples disagreeing with it
            m_rose_now = 0;
            if (m_bs != m_level) begin
                m_run++;
                if (m_run == D) begin
                    m_level = m_bs; m_run = 0; m_rose_now = m_bs;
                end
            end else begin
                m_run = 0;
            end
            m_fire = 0;
            if (m_run_old) begin
                m_auto_n++;
                if (m_auto_n == P) begin m_fire = 1; m_auto_n = 0; end
            end else begin
                m_auto_n = 0;
            end
            m_pulse = m_run_old ? m_fire : m_rose_prev;
            m_rose_prev = m_rose_now;
            m_count = m_count + 16'(m_pulse);

            m_k++;
            if (m_k % (4 * R) == 0)
                m_snap = half_sel ? (show_pc ? pc_in[31:16] : probe_data[31:16])
                                  : (show_pc ? pc_in[15:0]  : probe_data[15:0]);
            m_d  = (m_k / R) % 4;
            m_an = ~(4'b0001 << m_d);
            m_seg = HEX[m_snap[4*m_d +: 4]];
            m_dp = !(m_d == 3 && half_sel);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("step_pulse", {31'd0, step_pulse}, {31'd0, m_pulse});
            chk("step_count", {16'd0, step_count}, {16'd0, m_count});
            chk("an",         {28'd0, an},         {28'd0, m_an});
            chk("seg",        {25'd0, seg},        {25'd0, m_seg});
            chk("dp",         {31'd0, dp},         {31'd0, m_dp});
        end
    end

    int npulse, pulse_at;

    task automatic watch(input int n);
        npulse = 0; pulse_at = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (step_pulse === 1'b1) begin
                npulse++;
                if (pulse_at == 0) pulse_at = i;
            end
        end
    endtask

    initial begin
        reset = 1; step_btn = 0; show_pc = 1; half_sel = 0;
        pc_in = 32'h0040_001C; probe_data = 32'hA5B6_C7D8;
`ifdef STEP_DISPLAY_AUTO_RUN_EN
        run_sw = 0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_an",    {28'd0, an},         32'hE);
        chk("rst_seg",   {25'd0, seg},        32'h7F);
        chk("rst_dp",    {31'd0, dp},         32'h1);
        chk("rst_pulse", {31'd0, step_pulse}, 32'h0);
        chk("rst_count", {16'd0, step_count}, 32'h0);
        reset = 0;

        // Bouncy press, then settle high
        for (int i = 0; i < 4; i++) begin
            step_btn = (i % 2 == 0);
            @(negedge clk);
        end
        step_btn = 1;
        watch(10);
        chk("press_latency", pulse_at, 7);
        chk("press_pulses",  npulse, 1);
        chk("press_count",   {16'd0, step_count}, 32'd1);
        step_btn = 0;
        watch(12);
        chk("release_pulses", npulse, 0);
        chk("release_count",  {16'd0, step_count}, 32'd1);

        // Three-cycle glitch must be rejected
        step_btn = 1;
        repeat (3) @(negedge clk);
        step_btn = 0;
        watch(12);
        chk("glitch_pulses", npulse, 0);
        chk("glitch_count",  {16'd0, step_count}, 32'd1);

        // Display scan, with half_sel flipped while digit 1 is lit
        reset = 1;
        @(negedge clk);
        reset = 0;
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk);
            case (k)
                3:  begin chk("pre_snap_seg", {25'd0, seg}, 32'h40); chk("pre_snap_an", {28'd0, an}, 32'hD); end
                14: begin chk("d0_seg", {25'd0, seg}, 32'h46); chk("d0_an", {28'd0, an}, 32'hE); end
                17: begin chk("d1_seg", {25'd0, seg}, 32'h79); chk("d1_an", {28'd0, an}, 32'hD); end
                20: begin chk("d2_seg", {25'd0, seg}, 32'h40); chk("d2_an", {28'd0, an}, 32'hB); end
                23: begin chk("d3_seg", {25'd0, seg}, 32'h40); chk("d3_an", {28'd0, an}, 32'h7);
                          chk("d3_dp_low", {31'd0, dp}, 32'h1); end
                29: chk("old_word_d1", {25'd0, seg}, 32'h79);
                33: chk("hi_dp_d3", {31'd0, dp}, 32'h0);
                39: begin chk("hi_d1_seg", {25'd0, seg}, 32'h19); chk("hi_d1_an", {28'd0, an}, 32'hD);
                          chk("hi_d1_dp", {31'd0, dp}, 32'h1); end
                45: begin chk("hi_d3_dp", {31'd0, dp}, 32'h0); chk("hi_d3_an", {28'd0, an}, 32'h7); end
                default: ;
            endcase
            if (k == 27) half_sel = 1;
        end

        // Button held through a mid-operation reset still yields one pulse
        show_pc = 0; half_sel = 0;
        step_btn = 1;
        repeat (2) @(negedge clk);
        reset = 1;
        repeat (2) @(negedge clk);
        chk("midrst_count", {16'd0, step_count}, 32'd0);
        chk("midrst_an",    {28'd0, an},         32'hE);
        reset = 0;
        watch(12);
        chk("held_latency", pulse_at, 7);
        chk("held_pulses",  npulse, 1);
        chk("held_count",   {16'd0, step_count}, 32'd1);
        step_btn = 0;
        watch(12);
        chk("held_release", npulse, 0);

`ifdef STEP_DISPLAY_AUTO_RUN_EN
        reset = 1;
        @(negedge clk);
        reset = 0;
        run_sw = 1;
        npulse = 0;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            if (step_pulse === 1'b1) npulse++;
            if (i == 3)  step_btn = 1;
            if (i == 11) step_btn = 0;
        end
        chk("auto_pulses", npulse, 4);
        chk("auto_count",  {16'd0, step_count}, 32'd4);
        run_sw = 0;
        watch(12);
        chk("auto_off_pulses", npulse, 0);
        chk("auto_off_count",  {16'd0, step_count}, 32'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
